// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_arbiter
//  Description : Two-port (instruction fetch / data) front end for a single
//                DMA channel. Arbitrates between the ports (alternating on a
//                tie), latches the winning transaction onto the m_* bus, and
//                pulses m_start. It then waits for m_busy to fall, or for a
//                TIMEOUT-cycle abort, and returns the result to the owner as
//                a one-cycle ready pulse.
//
//  Ports       : clk, reset           - clock, async active-high reset
//                if_req/if_addr       - fetch request (held until if_ready)
//                if_ready/if_rdata    - fetch completion pulse / instruction
//                d_req/d_we/d_be      - data request, write flag, byte enables
//                d_addr/d_wdata       - data address / write data
//                d_ready/d_rdata      - data completion pulse / read data
//                err                  - timeout flag, pulses with a ready
//                m_start              - one-cycle DMA launch pulse
//                m_addr/m_wdata       - latched transaction address / data
//                m_write/m_be         - latched write flag / byte enables
//                m_busy/m_rdata       - DMA busy, read data valid on busy fall
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        m_start,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    output logic [3:0]  m_be,
    input  logic        m_busy,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_ARM   = 3'd2;
    localparam logic [2:0] c_S_WAIT  = 3'd3;
    localparam logic [2:0] c_S_RESP  = 3'd4;

    // The counter holds the number of busy WAIT cycles already seen, so the
    // abort fires on the TIMEOUT-th busy WAIT cycle.
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_owner_data;   // 1 = data port owns the transaction
    logic        r_last_data;    // 1 = last grant went to the data port
    logic        r_timed_out;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic        r_m_write;
    logic [3:0]  r_m_be;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_any_req;
    logic        w_grant_data;
    logic        w_wait_done;
    logic        w_wait_expired;

    assign w_any_req      = if_req | d_req;
    // Data wins when it is alone, or on a tie when fetch was granted last.
    assign w_grant_data   = d_req & (~if_req | ~r_last_data);
    assign w_wait_done    = ~m_busy;
    assign w_wait_expired = m_busy & (r_wait_cnt == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        m_start      = 1'b0;
        if_ready     = 1'b0;
        d_ready      = 1'b0;
        err          = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                m_start      = 1'b1;
                w_state_next = c_S_ARM;
            end
            // m_busy is not yet valid in the cycle after m_start.
            c_S_ARM: begin
                w_state_next = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (w_wait_done || w_wait_expired) begin
                    w_state_next = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if_ready     = ~r_owner_data;
                d_ready      = r_owner_data;
                err          = r_timed_out;
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant latch, wait counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_data <= 1'b0;
            r_last_data  <= 1'b0;
            r_timed_out  <= 1'b0;
            r_wait_cnt   <= 16'd0;
            r_m_addr     <= 32'd0;
            r_m_wdata    <= 32'd0;
            r_m_write    <= 1'b0;
            r_m_be       <= 4'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_data <= w_grant_data;
                        r_last_data  <= w_grant_data;
                        r_timed_out  <= 1'b0;
                        if (w_grant_data) begin
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            r_m_write <= d_we;
                            r_m_be    <= d_we ? d_be : 4'b0000;
                        end else begin
                            r_m_addr  <= if_addr;
                            r_m_wdata <= 32'd0;
                            r_m_write <= 1'b0;
                            r_m_be    <= 4'b0000;
                        end
                    end
                end
                c_S_ISSUE: begin
                    r_wait_cnt <= 16'd0;
                end
                c_S_WAIT: begin
                    if (w_wait_done) begin
                        // Writes leave the owner's read data untouched.
                        if (!r_m_write) begin
                            if (r_owner_data) begin
                                r_d_rdata <= m_rdata;
                            end else begin
                                r_if_rdata <= m_rdata;
                            end
                        end
                    end else if (w_wait_expired) begin
                        r_timed_out <= 1'b1;
                        if (r_owner_data) begin
                            r_d_rdata <= 32'hFFFF_FFFF;
                        end else begin
                            r_if_rdata <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_write  = r_m_write;
    assign m_be     = r_m_be;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire
